calc_core_param: RTL and testbench

//  Parametrised sequential decimal calculator core, successor to calc_top: DIGITS-wide entry,

---
 rtl/calc_core_param.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_calc_core_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_core_param.sv
`default_nettype none
// ============================================================================
// Module   : calc_core_param
// Purpose  : Sequential signed decimal calculator core (add/sub/mul), DIGITS
//            seven-segment outputs, shift-add multiply and double-dabble render.
// Revision : 1.0 - initial release
// ============================================================================
module calc_core_param #(
    parameter int DIGITS         = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] cmd,
    input  logic       cmd_valid,
    output logic [6:0] displays [DIGITS-1:0],
    output logic [1:0] status
);
    localparam int W       = $clog2(10**DIGITS);
    localparam int c_cnt_w = $clog2(W);
    localparam int c_bcd_w = 4 * DIGITS;

    localparam logic [W-1:0]        c_ten        = W'(10);
    localparam logic [W-1:0]        c_entry_full = W'(10**(DIGITS-1));
    localparam logic signed [W+1:0] c_max_s      = (W+2)'(10**DIGITS - 1);
    localparam logic signed [W+1:0] c_min_s      = (W+2)'(-(10**(DIGITS-1) - 1));
    localparam logic [2*W-1:0]      c_max_2w     = (2*W)'(10**DIGITS - 1);
    localparam logic [2*W-1:0]      c_negmax_2w  = (2*W)'(10**(DIGITS-1) - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last   = c_cnt_w'(W - 1);

    localparam logic [1:0] c_op_none = 2'd0;
    localparam logic [1:0] c_op_add  = 2'd1;
    localparam logic [1:0] c_op_sub  = 2'd2;
    localparam logic [1:0] c_op_mul  = 2'd3;

    localparam logic [6:0] c_seg_blank = 7'h00;
    localparam logic [6:0] c_seg_zero  = 7'h3F;
    localparam logic [6:0] c_seg_minus = 7'h40;
    localparam logic [6:0] c_seg_err   = 7'h79;

    typedef enum logic [2:0] {
        ST_READY = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MUL   = 3'd2,
        ST_CONV  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [3:0]           r_cmd;
    logic [W-1:0]         r_entry, w_entry;
    logic [W:0]           r_acc, w_acc;
    logic [1:0]           r_op, w_op;
    logic                 r_started, w_started;
    logic                 r_after_eq, w_after_eq;
    logic                 r_err, w_err;
    logic                 w_do_mul, w_eval;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 w_cnt_last, w_accept;
    logic [2*W-1:0]       r_mcand, r_prod, w_prod_step;
    logic [W-1:0]         r_mplier;
    logic                 r_prod_neg;
    logic [W:0]           w_mul_res;
    logic                 w_mul_ovf;
    logic signed [W+1:0]  w_addsub;
    logic                 w_addsub_ovf;
    logic [W-1:0]         r_bin;
    logic [c_bcd_w-1:0]   r_bcd, w_bcd_adj, w_bcd_fin;
    logic                 r_neg;
    logic [3:0]           w_msd;
    logic [6:0]           w_render [DIGITS-1:0];
    logic [6:0]           r_disp   [DIGITS-1:0];

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [W-1:0] f_mag(input logic [W:0] a);
        return W'(a[W] ? -a : a);
    endfunction

    assign w_accept   = cmd_valid && ((r_state == ST_READY) ||
                                      (r_state == ST_ERROR && cmd == 4'hF));
    assign w_cnt_last = (r_cnt == c_cnt_last);

    always_comb begin
        case (r_state)
            ST_READY: status = 2'b01;
            ST_ERROR: status = 2'b00;
            default:  status = 2'b10;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_READY;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_READY, ST_ERROR: if (w_accept) w_state_nxt = ST_EXEC;
            ST_EXEC:  w_state_nxt = w_do_mul ? ST_MUL : ST_CONV;
            ST_MUL:   if (w_cnt_last) w_state_nxt = ST_CONV;
            ST_CONV:  if (w_cnt_last) w_state_nxt = r_err ? ST_ERROR : ST_READY;
            default:  w_state_nxt = ST_READY;
        endcase
    end

    // Add/sub evaluated in two extra bits so overflow is a plain signed compare
    assign w_addsub = (r_op == c_op_sub)
                    ? $signed({r_acc[W], r_acc}) - $signed({2'b00, r_entry})
                    : $signed({r_acc[W], r_acc}) + $signed({2'b00, r_entry});
    assign w_addsub_ovf = (w_addsub > c_max_s) || (w_addsub < c_min_s);

    // Command decode: next operand/accumulator state, applied in EXEC
    always_comb begin
        w_entry    = r_entry;
        w_acc      = r_acc;
        w_op       = r_op;
        w_started  = r_started;
        w_after_eq = r_after_eq;
        w_err      = 1'b0;
        w_eval     = 1'b0;
        w_do_mul   = 1'b0;
        if (r_cmd <= 4'd9) begin
            if (r_after_eq) begin
                w_acc      = '0;
                w_op       = c_op_none;
                w_entry    = {{(W-4){1'b0}}, r_cmd};
                w_started  = 1'b1;
                w_after_eq = 1'b0;
            end else if (!r_started) begin
                w_entry   = {{(W-4){1'b0}}, r_cmd};
                w_started = 1'b1;
            end else if (r_entry < c_entry_full) begin
                w_entry = r_entry * c_ten + {{(W-4){1'b0}}, r_cmd};
            end
        end else begin
            case (r_cmd)
                4'hA, 4'hB, 4'hC: begin
                    if (r_op != c_op_none && r_started) w_eval = 1'b1;
                    else if (r_started)                 w_acc  = {1'b0, r_entry};
                    w_op       = (r_cmd == 4'hA) ? c_op_add :
                                 (r_cmd == 4'hB) ? c_op_sub : c_op_mul;
                    w_entry    = '0;
                    w_started  = 1'b0;
                    w_after_eq = 1'b0;
                end
                4'hD: if (r_started) w_entry = r_entry / c_ten;
                4'hE: if (r_op != c_op_none) begin
                    w_eval     = 1'b1;
                    w_op       = c_op_none;
                    w_entry    = '0;
                    w_started  = 1'b0;
                    w_after_eq = 1'b1;
                end
                4'hF: begin
                    w_entry    = '0;
                    w_acc      = '0;
                    w_op       = c_op_none;
                    w_started  = 1'b0;
                    w_after_eq = 1'b0;
                end
                default: ;
            endcase
        end
        if (w_eval) begin
            if (r_op == c_op_mul) begin
                w_do_mul = 1'b1;
            end else begin
                w_acc = w_addsub[W:0];
                w_err = w_addsub_ovf;
            end
        end
    end

    // Shift-add multiply on magnitudes; sign re-applied on exit
    assign w_prod_step = r_mplier[0] ? r_prod + r_mcand : r_prod;
    assign w_mul_res   = r_prod_neg ? -(W+1)'(w_prod_step) : (W+1)'(w_prod_step);
    assign w_mul_ovf   = r_prod_neg ? (w_prod_step > c_negmax_2w) : (w_prod_step > c_max_2w);

    for (genvar g = 0; g < DIGITS; g++) begin : g_dd
        assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                              : r_bcd[4*g +: 4];
    end
    assign w_bcd_fin = {w_bcd_adj[c_bcd_w-2:0], r_bin[W-1]};

    always_comb begin
        w_msd = '0;
        for (int i = 1; i < DIGITS; i++)
            if (w_bcd_fin[4*i +: 4] != 4'd0) w_msd = 4'(i);
        for (int i = 0; i < DIGITS; i++) begin
            if (4'(i) <= w_msd)                        w_render[i] = f_seg(w_bcd_fin[4*i +: 4]);
            else if (r_neg && 4'(i) == w_msd + 4'd1)   w_render[i] = c_seg_minus;
            else                                       w_render[i] = c_seg_blank;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cmd      <= '0;
            r_entry    <= '0;
            r_acc      <= '0;
            r_op       <= c_op_none;
            r_started  <= 1'b0;
            r_after_eq <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_prod_neg <= 1'b0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_neg      <= 1'b0;
            for (int i = 0; i < DIGITS; i++)
                r_disp[i] <= (i == 0) ? c_seg_zero : c_seg_blank;
        end else begin
            case (r_state)
                ST_READY, ST_ERROR: if (w_accept) r_cmd <= cmd;
                ST_EXEC: begin
                    r_entry    <= w_entry;
                    r_acc      <= w_acc;
                    r_op       <= w_op;
                    r_started  <= w_started;
                    r_after_eq <= w_after_eq;
                    r_err      <= w_err;
                    r_cnt      <= '0;
                    r_mcand    <= {{W{1'b0}}, f_mag(r_acc)};
                    r_mplier   <= r_entry;
                    r_prod     <= '0;
                    r_prod_neg <= r_acc[W];
                    r_bin      <= w_started ? w_entry : f_mag(w_acc);
                    r_neg      <= !w_started && w_acc[W];
                    r_bcd      <= '0;
                end
                ST_MUL: begin
                    r_prod   <= w_prod_step;
                    r_mcand  <= {r_mcand[2*W-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[W-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        r_acc <= w_mul_res;
                        r_err <= w_mul_ovf;
                        r_bin <= w_prod_step[W-1:0];
                        r_neg <= r_prod_neg && (w_prod_step != '0);
                        r_bcd <= '0;
                    end
                end
                ST_CONV: begin
                    {r_bcd, r_bin} <= {w_bcd_fin, r_bin[W-2:0], 1'b0};
                    r_cnt          <= r_cnt + 1'b1;
                    if (w_cnt_last) begin
                        for (int i = 0; i < DIGITS; i++)
                            r_disp[i] <= r_err ? ((i == 0) ? c_seg_err : c_seg_blank)
                                               : w_render[i];
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_out
        assign displays[g] = SEG_ACTIVE_LOW ? ~r_disp[g] : r_disp[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_core_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_core_param
// Purpose  : Scoreboard bench for calc_core_param (DIGITS=8) with a decimal
//            reference model of the calculator behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_core_param;
    localparam int DIGITS = 8;
    localparam int W      = $clog2(10**DIGITS);
    localparam int LAT    = W + 1;
    localparam int LAT_M  = 2 * W + 1;
    localparam longint MAXV = 64'd99999999;
    localparam longint MINV = -64'sd9999999;

    typedef struct packed {
        logic [1:0]  st;
        logic [55:0] disp;
        logic [7:0]  lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cmd = '0;
    logic       cmd_valid = 1'b0;
    logic [6:0] displays [DIGITS-1:0];
    logic [1:0] status;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q[$];

    longint m_entry, m_acc;
    int     m_op;
    bit     m_started, m_after_eq, m_err, m_mul_eval;

    calc_core_param #(.DIGITS(DIGITS), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clock(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .displays(displays), .status(status)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [55:0] dut_disp();
        logic [55:0] d;
        for (int i = 0; i < DIGITS; i++) d[7*i +: 7] = displays[i];
        return d;
    endfunction

    function automatic logic [6:0] seg(input longint d);
        logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[int'(d)];
    endfunction

    function automatic logic [55:0] render(input longint v);
        logic [55:0] r = '0;
        longint m = (v < 0) ? -v : v;
        int i = 0;
        do begin
            r[7*i +: 7] = seg(m % 10);
            m = m / 10;
            i++;
        end while (m != 0);
        if (v < 0) r[7*i +: 7] = 7'h40;
        return r;
    endfunction

    function automatic int ndig(input longint v);
        int n = 1;
        while (v >= 10) begin v = v / 10; n++; end
        return n;
    endfunction

    function automatic void model_reset();
        m_entry = 0; m_acc = 0; m_op = 0;
        m_started = 0; m_after_eq = 0; m_err = 0;
    endfunction

    function automatic void model_eval();
        longint r;
        case (m_op)
            1:       r = m_acc + m_entry;
            2:       r = m_acc - m_entry;
            default: r = m_acc * m_entry;
        endcase
        m_mul_eval = (m_op == 3);
        if (r > MAXV || r < MINV) m_err = 1;
        else                      m_acc = r;
    endfunction

    function automatic exp_t model_step(input logic [3:0] c);
        exp_t e;
        m_mul_eval = 0;
        if (c <= 4'd9) begin
            if (m_after_eq) begin
                m_acc = 0; m_op = 0; m_entry = longint'(c); m_started = 1; m_after_eq = 0;
            end else if (!m_started) begin
                m_entry = longint'(c); m_started = 1;
            end else if (ndig(m_entry) < DIGITS) begin
                m_entry = m_entry * 10 + longint'(c);
            end
        end else if (c <= 4'hC) begin
            if (m_op != 0 && m_started) model_eval();
            else if (m_started)         m_acc = m_entry;
            m_op = int'(c) - 9;
            m_entry = 0; m_started = 0; m_after_eq = 0;
        end else if (c == 4'hD) begin
            if (m_started) m_entry = m_entry / 10;
        end else if (c == 4'hE) begin
            if (m_op != 0) begin
                model_eval();
                m_op = 0; m_entry = 0; m_started = 0; m_after_eq = 1;
            end
        end else begin
            model_reset();
        end
        e.lat  = m_mul_eval ? 8'(LAT_M) : 8'(LAT);
        e.st   = m_err ? 2'b00 : 2'b01;
        e.disp = m_err ? {49'b0, 7'h79} : render(m_started ? m_entry : m_acc);
        return e;
    endfunction

    // Monitor: one scoreboard entry per busy episode
    initial begin
        int busy = 0;
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                busy = 0;
            end else if (status == 2'b10) begin
                busy++;
            end else if (busy > 0) begin
                if (q.size() == 0) begin
                    check("unexpected_completion", 64'(busy), 64'(0));
                end else begin
                    e = q.pop_front();
                    check("status", 64'(status), 64'(e.st));
                    check("displays", 64'(dut_disp()), 64'(e.disp));
                    check("busy_cycles", 64'(busy), 64'(e.lat));
                end
                busy = 0;
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (status == 2'b10 && k < 300) begin @(negedge clk); k++; end
        if (status == 2'b10) check("idle_timeout", 64'(status), 64'(1));
    endtask

    task automatic send(input logic [3:0] c, input int hold);
        bit acc;
        wait_idle();
        acc = !m_err || (c == 4'hF);
        cmd = c;
        cmd_valid = 1'b1;
        if (acc) q.push_back(model_step(c));
        @(negedge clk);
        if (acc) begin
            for (int k = 0; k < hold; k++) begin
                cmd = 4'($urandom);
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        if (!acc) repeat (3) @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_status", 64'(status), 64'(2'b01));
        check("reset_displays", 64'(dut_disp()), 64'(7'h3F));
        @(negedge clk);
        reset = 1'b0;

        send(4'd1, 0); send(4'd2, 0); send(4'hA, 0); send(4'd3, 0); send(4'hE, 0);
        send(4'd5, 0); send(4'hB, 0); send(4'd9, 0); send(4'hE, 0);
        send(4'd7, 3); send(4'hC, 4); send(4'd6, 2); send(4'hE, 6);
        send(4'hF, 0);
        for (int d = 1; d <= 9; d++) send(4'(d), 0);
        send(4'hD, 1);
        send(4'hF, 0);
        for (int d = 0; d < 8; d++) send(4'd9, 0);
        send(4'hC, 0); send(4'd2, 0); send(4'hE, 0);
        send(4'd5, 0);
        send(4'hE, 0);
        send(4'hF, 0);

        // Equals on a pending multiply, aborted by reset while multiplying
        send(4'd7, 0); send(4'hC, 0); send(4'd6, 0);
        wait_idle();
        cmd = 4'hE;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midmul_busy", 64'(status), 64'(2'b10));
        reset = 1'b1;
        q.delete();
        model_reset();
        @(posedge clk); #1;
        check("midmul_rst_status", 64'(status), 64'(2'b01));
        check("midmul_rst_displays", 64'(dut_disp()), 64'(7'h3F));
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 150; n++) begin
            int r;
            logic [3:0] c;
            r = int'($urandom_range(0, 99));
            if (m_err)        c = (r < 50) ? 4'hF : 4'($urandom_range(0, 14));
            else if (r < 55)  c = 4'($urandom_range(0, 9));
            else if (r < 70)  c = 4'($urandom_range(10, 12));
            else if (r < 82)  c = 4'hE;
            else if (r < 94)  c = 4'hD;
            else              c = 4'hF;
            send(c, int'($urandom_range(0, 4)));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
